// File: rtl/wb_mem_ppfifo_sink.sv
// Wishbone write sink that streams 32-bit words into a ping-pong FIFO and pulses o_wbs_int on each buffer release.
// Optional: define WB_MEM_PPFIFO_SINK_FLUSH_ON_CYC_EN to also release a partial buffer when the master drops cyc.
module wb_mem_ppfifo_sink #(
    parameter int SIZE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wbs_we,
    input  logic                  i_wbs_cyc,
    input  logic                  i_wbs_stb,
    input  logic [3:0]            i_wbs_sel,
    input  logic [31:0]           i_wbs_adr,
    input  logic [31:0]           i_wbs_dat,
    output logic [31:0]           o_wbs_dat,
    output logic                  o_wbs_ack,
    output logic                  o_wbs_int,
    input  logic [1:0]            i_wr_rdy,
    output logic [1:0]            o_wr_act,
    input  logic [SIZE_WIDTH-1:0] i_wr_size,
    output logic                  o_wr_stb,
    output logic [31:0]           o_wr_data
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    state_t                state;
    logic [SIZE_WIDTH-1:0] count;
    logic [SIZE_WIDTH-1:0] size_q;
    logic                  wr_req;
    logic                  rd_req;
    logic                  flush;
    logic [23:0]           count24;
    logic                  unused_ok;

    // Address and byte selects carry no meaning for a streaming sink.
    assign unused_ok = ^{i_wbs_sel, i_wbs_adr};

    assign wr_req  = i_wbs_cyc & i_wbs_stb & i_wbs_we & ~o_wbs_ack;
    assign rd_req  = i_wbs_cyc & i_wbs_stb & ~i_wbs_we & ~o_wbs_ack;
    assign count24 = 24'(count);

`ifdef WB_MEM_PPFIFO_SINK_FLUSH_ON_CYC_EN
    logic cyc_q;

    always_ff @(posedge clk) begin
        if (rst) cyc_q <= 1'b0;
        else     cyc_q <= i_wbs_cyc;
    end

    // End of a bus burst commits whatever has been written so far.
    assign flush = cyc_q & ~i_wbs_cyc & (count != '0);
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            size_q    <= '0;
            o_wbs_dat <= '0;
            o_wbs_ack <= 1'b0;
            o_wbs_int <= 1'b0;
            o_wr_act  <= 2'b00;
            o_wr_stb  <= 1'b0;
            o_wr_data <= '0;
        end else begin
            o_wbs_ack <= 1'b0;
            o_wr_stb  <= 1'b0;
            o_wbs_int <= 1'b0;

            if (rd_req) begin
                o_wbs_ack <= 1'b1;
                o_wbs_dat <= {5'b0, state == ACTIVE, o_wr_act, count24};
            end

            case (state)
                IDLE: begin
                    if (o_wr_act == 2'b00 && i_wr_rdy != 2'b00 && i_wr_size != '0) begin
                        o_wr_act <= i_wr_rdy[0] ? 2'b01 : 2'b10;
                        size_q   <= i_wr_size;
                        count    <= '0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (wr_req) begin
                        o_wr_stb  <= 1'b1;
                        o_wr_data <= i_wbs_dat;
                        o_wbs_ack <= 1'b1;
                        count     <= count + SIZE_WIDTH'(1);
                        if (count + SIZE_WIDTH'(1) == size_q)
                            state <= RELEASE;
                    end else if (flush) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    o_wr_act  <= 2'b00;
                    o_wbs_int <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
